// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - Op-code localparams OP_AND..OP_MUL (3-bit op field); 101-111 are reserved.
//   - FSM state enum alu_state_e. MUL_BUSY exists only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

`ifdef ALU_MUL_EN
  typedef enum logic {
    IDLE,
    MUL_BUSY
  } alu_state_e;
`else
  typedef enum logic {
    IDLE
  } alu_state_e;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, low WIDTH bits of a x b.
// Built only when ALU_MUL_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and begin (count restarts at 0)
//   ack         consumer took the product; clears busy once done
//   a, b        operands (WIDTH)
//   busy        operation in flight or holding a finished product
//   done        WIDTH steps completed; product valid and held
//   product     truncated product (WIDTH)
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != LastCnt) begin
        // Bits shifted past WIDTH never reach the truncated product, so drop them.
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end else if (ack) begin
        // Count stays saturated at WIDTH until the product is taken.
        busy_q <= 1'b0;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LastCnt);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU (AND/OR/ADD/SLT, NOR/SUB via ainvert/binvert) with
// valid/ready on both sides and registered zero/carry/overflow/illegal flags.
// Optional macro ALU_MUL_EN: adds an iterative unsigned multiply (op 100, WIDTH+1 cycle
// latency). Without it op 100 is treated as reserved.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   src1, src2           operands (WIDTH)
//   ainvert, binvert     operand inversion; binvert is also carry-in
//   op                   3-bit operation
//   out_valid/out_ready  result handshake
//   result               result (WIDTH)
//   zero/carry/overflow  result flags; carry/overflow only for ADD/SLT
//   illegal              reserved op
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q, overflow_q, illegal_q, out_valid_q;

  logic             slot_free, accept;
  logic [WIDTH-1:0] a_p, b_p;
  logic [WIDTH:0]   sum_ext;
  logic             sum_ovf;
  logic [WIDTH-1:0] slice_result;
  logic             slice_carry, slice_ovf, slice_illegal;

  // Output slot can take a new result when empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // Combinational slice datapath.
  always_comb begin
    a_p           = ainvert ? ~src1 : src1;
    b_p           = binvert ? ~src2 : src2;
    sum_ext       = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, binvert};
    sum_ovf       = (a_p[WIDTH-1] == b_p[WIDTH-1]) && (sum_ext[WIDTH-1] != a_p[WIDTH-1]);
    slice_result  = '0;
    slice_carry   = 1'b0;
    slice_ovf     = 1'b0;
    slice_illegal = 1'b0;
    case (op)
      OP_AND: slice_result = a_p & b_p;
      OP_OR:  slice_result = a_p | b_p;
      OP_ADD: begin
        slice_result = sum_ext[WIDTH-1:0];
        slice_carry  = sum_ext[WIDTH];
        slice_ovf    = sum_ovf;
      end
      OP_SLT: begin
        // Sign of the true difference: sum MSB corrected by signed overflow.
        slice_result = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ sum_ovf};
        slice_carry  = sum_ext[WIDTH];
        slice_ovf    = sum_ovf;
      end
      default: slice_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic             mul_start, mul_ack, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && (op == OP_MUL);
  assign mul_ack   = (state_q == MUL_BUSY) && slot_free;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .ack     (mul_ack),
    .a       (a_p),
    .b       (b_p),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      // Drop valid on handshake; a same-cycle load below re-asserts it.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
              state_q <= MUL_BUSY;
            end else begin
`else
            begin
`endif
              result_q    <= slice_result;
              zero_q      <= (slice_result == '0);
              carry_q     <= slice_carry;
              overflow_q  <= slice_ovf;
              illegal_q   <= slice_illegal;
              out_valid_q <= 1'b1;
            end
          end
        end
`ifdef ALU_MUL_EN
        MUL_BUSY: begin
          if (mul_busy && mul_done && slot_free) begin
            result_q    <= mul_product;
            zero_q      <= (mul_product == '0);
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=8, plus hand sequences for
// back-to-back throughput, multiply latency, output stall and reset during multiply.
// MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] src1 = '0;
  logic [WIDTH-1:0] src2 = '0;
  logic             ainvert = 1'b0;
  logic             binvert = 1'b0;
  logic [2:0]       op = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             zero, carry, overflow, illegal;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .ainvert   (ainvert),
    .binvert   (binvert),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  typedef struct {
    logic [2:0] op;
    logic       ainv;
    logic       binv;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       il;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] o, input logic ai, input logic bi,
                       input logic [7:0] a, input logic [7:0] b);
    op       = o;
    ainvert  = ai;
    binvert  = bi;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] res, input logic z,
                           input logic c, input logic v, input logic il);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".result"},    {24'b0, result},    {24'b0, res});
    chk({tag, ".zero"},      {31'b0, zero},      {31'b0, z});
    chk({tag, ".carry"},     {31'b0, carry},     {31'b0, c});
    chk({tag, ".overflow"},  {31'b0, overflow},  {31'b0, v});
    chk({tag, ".illegal"},   {31'b0, illegal},   {31'b0, il});
  endtask

  vec_t vecs[$];

  initial begin
    //                op      ai    bi    a      b      res    z     c     v     il
    vecs.push_back('{3'b010, 1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0}); // ADD ovf
    vecs.push_back('{3'b010, 1'b0, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}); // SUB zero
    vecs.push_back('{3'b011, 1'b0, 1'b1, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0}); // SLT -128<1
    vecs.push_back('{3'b011, 1'b0, 1'b1, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}); // SLT 1<-128
    vecs.push_back('{3'b000, 1'b1, 1'b1, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}); // NOR
    vecs.push_back('{3'b001, 1'b0, 1'b0, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0}); // OR
    vecs.push_back('{3'b000, 1'b0, 1'b0, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0}); // AND
    vecs.push_back('{3'b010, 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}); // ADD wrap
    vecs.push_back('{3'b001, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}); // ~A|B
    vecs.push_back('{3'b101, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}); // reserved
    vecs.push_back('{3'b111, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}); // reserved

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst.result",    {24'b0, result},    32'd0);
    chk("rst.flags",     {28'b0, zero, carry, overflow, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle ops
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
      drive(vecs[i].op, vecs[i].ainv, vecs[i].binv, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v,
                vecs[i].il);
    end
    @(posedge clk);
    #1;
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

    // Back-to-back: four accepts, four consecutive valid cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(3'b010, 1'b0, 1'b0, 8'(i), 8'(i + 1));
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d.out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("b2b%0d.result", i), {24'b0, result}, 32'(2 * i + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b.end_valid", {31'b0, out_valid}, 32'd0);

    // Multiply 0x0F * 0x11
    @(negedge clk);
    drive(3'b100, 1'b0, 1'b0, 8'h0F, 8'h11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef ALU_MUL_EN
    chk("mul.c0.in_ready", {31'b0, in_ready}, 32'd0);
    chk("mul.c0.out_valid", {31'b0, out_valid}, 32'd0);
    for (int k = 1; k <= int'(WIDTH); k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mul.c%0d.in_ready", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("mul.c%0d.out_valid", k), {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    check_out("mul", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mul.done.in_ready", {31'b0, in_ready}, 32'd1);
`else
    check_out("mul_rsvd", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    @(posedge clk);
    #1;
    chk("mul.drain", {31'b0, out_valid}, 32'd0);

    // Output stall with a pending request held
    @(negedge clk);
    out_ready = 1'b0;
    drive(3'b010, 1'b0, 1'b0, 8'h01, 8'h01);
    @(posedge clk);
    #1;
    drive(3'b010, 1'b0, 1'b0, 8'h03, 8'h04);
    check_out("stall.first", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d.out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d.result", k), {24'b0, result}, 32'h02);
      chk($sformatf("stall%0d.in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("stall.release.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("stall.second", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("stall.drain", {31'b0, out_valid}, 32'd0);

    // Async reset at multiply cycle 4
    @(negedge clk);
    drive(3'b100, 1'b0, 1'b0, 8'h0F, 8'h11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmul.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmul.in_ready",  {31'b0, in_ready},  32'd1);
    chk("rstmul.result",    {24'b0, result},    32'd0);
    chk("rstmul.flags",     {28'b0, zero, carry, overflow, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(3'b010, 1'b0, 1'b0, 8'h02, 8'h03);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("post_rst_add", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
